// File: rtl/hex_display_feeder.sv
// ---------------------------------------------------------------------------
// hex_display_feeder
//
// Front end for the seven-segment digit bank. It accepts one binary value per
// valid/ready transfer and turns it into DIGITS 4-bit digit codes. Each code is
// either a raw hex nibble or a decimal BCD digit. Decimal conversion uses
// serial double-dabble, one bit per clock. The block also produces per-digit
// enables so that leading zeros can be blanked. The display-facing outputs
// change only on the single UPDATE edge, so the downstream decoders never see
// a partially converted value.
//
// Parameters
//   WIDTH     input value width (must be <= 4*DIGITS)
//   DIGITS    number of display digits
//
// Ports
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   in_valid  source offers in_data / in_hex / in_blank
//   in_ready  value can be accepted (high only in IDLE)
//   in_data   value to display
//   in_hex    1 = raw hex nibbles, 0 = decimal
//   in_blank  1 = blank leading zero digits
//   digits    digit codes, digit 0 (rightmost) in bits [3:0]
//   digit_en  per-digit display enable
//   overflow  last decimal value exceeded 10^DIGITS-1
//   busy      conversion or update in progress (== !in_ready)
// ---------------------------------------------------------------------------
module hex_display_feeder #(
   parameter int WIDTH  = 24,
   parameter int DIGITS = 6
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   input  logic                  in_hex,
   input  logic                  in_blank,
   output logic [4*DIGITS-1:0]   digits,
   output logic [DIGITS-1:0]     digit_en,
   output logic                  overflow,
   output logic                  busy
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(WIDTH + 1);

   // Largest value that still fits in DIGITS decimal digits.
   localparam logic [63:0]      MAX_DEC   = 64'(10 ** DIGITS) - 64'd1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CONV   = 2'd1,
      S_UPDATE = 2'd2
   } state_t;

   state_t             state_q;
   logic [BCD_W-1:0]   bcd_q;        // BCD accumulator, or hex/saturated digits
   logic [WIDTH-1:0]   val_q;        // binary value being shifted out
   logic [CNT_W-1:0]   cnt_q;        // completed double-dabble iterations
   logic               blank_q;      // captured in_blank
   logic               ovf_pend_q;   // overflow to publish at UPDATE
   logic [BCD_W-1:0]   digits_q;
   logic [DIGITS-1:0]  digit_en_q;
   logic               overflow_q;

   logic [BCD_W-1:0]   bcd_adj_d;    // BCD after the add-3 correction
   logic [DIGITS-1:0]  en_mask_d;    // enable mask computed from bcd_q
   logic               nz_seen;      // a non-zero digit exists at or above i
   logic               in_over;      // decimal input out of display range

   assign in_over = 64'(in_data) > MAX_DEC;

   // Double-dabble correction: any digit >= 5 gets +3 so that the following
   // left shift carries correctly into the next decimal digit.
   // NOTE: every combinational output gets a default before any conditional
   // write; a path that leaves it unassigned would infer a latch.
   always_comb begin
      bcd_adj_d = bcd_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // Leading-zero blanking: scan from the most significant digit down and
   // enable everything from the first non-zero digit. The units digit is
   // always lit so that zero still shows "0". A saturated overflow display
   // is shown in full.
   always_comb begin
      en_mask_d = '1;
      nz_seen   = 1'b0;
      if (blank_q && !ovf_pend_q) begin
         for (int i = DIGITS - 1; i >= 0; i--) begin
            nz_seen      = nz_seen | (|bcd_q[4*i +: 4]);
            en_mask_d[i] = nz_seen;
         end
      end
      en_mask_d[0] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         bcd_q      <= '0;
         val_q      <= '0;
         cnt_q      <= '0;
         blank_q    <= 1'b0;
         ovf_pend_q <= 1'b0;
         digits_q   <= '0;
         digit_en_q <= '1;
         overflow_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // in_ready is exactly "state is IDLE", so in_valid alone
               // marks a transfer here.
               if (in_valid) begin
                  blank_q <= in_blank;
                  cnt_q   <= '0;
                  if (in_hex) begin
                     bcd_q      <= BCD_W'(in_data);
                     ovf_pend_q <= 1'b0;
                     state_q    <= S_UPDATE;
                  end else if (in_over) begin
                     bcd_q      <= {DIGITS{4'h9}};
                     ovf_pend_q <= 1'b1;
                     state_q    <= S_UPDATE;
                  end else begin
                     bcd_q      <= '0;
                     val_q      <= in_data;
                     ovf_pend_q <= 1'b0;
                     state_q    <= S_CONV;
                  end
               end
            end

            S_CONV: begin
               // One double-dabble iteration: correct, then shift the next
               // binary bit into the BCD accumulator.
               {bcd_q, val_q} <= {bcd_adj_d, val_q} << 1;
               cnt_q          <= cnt_q + CNT_W'(1);
               if (cnt_q == LAST_ITER) begin
                  state_q <= S_UPDATE;
               end
            end

            S_UPDATE: begin
               digits_q   <= bcd_q;
               overflow_q <= ovf_pend_q;
               digit_en_q <= en_mask_d;
               state_q    <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready = (state_q == S_IDLE);
   assign busy     = (state_q != S_IDLE);
   assign digits   = digits_q;
   assign digit_en = digit_en_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_hex_display_feeder.sv
// ---------------------------------------------------------------------------
// tb_hex_display_feeder
//
// Scoreboard bench for hex_display_feeder. The driver pushes the expected
// display state and its due cycle for every accepted value. The monitor pops
// and compares whenever in_ready rises, which marks a completed update. While
// the block is busy, the monitor also checks that the displayed digits hold
// the previously shown value.
// ---------------------------------------------------------------------------
module tb_hex_display_feeder;

   localparam int WIDTH  = 24;
   localparam int DIGITS = 6;

   logic                 clk = 1'b0;
   logic                 reset_n = 1'b0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_data = '0;
   logic                 in_hex = 1'b0;
   logic                 in_blank = 1'b0;
   logic [4*DIGITS-1:0]  digits;
   logic [DIGITS-1:0]    digit_en;
   logic                 overflow;
   logic                 busy;

   hex_display_feeder #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_hex   (in_hex),
      .in_blank (in_blank),
      .digits   (digits),
      .digit_en (digit_en),
      .overflow (overflow),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [4*DIGITS-1:0] dig;
      logic [DIGITS-1:0]   en;
      logic                ovf;
      int                  t_done;
      int unsigned         value;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: derived from the display rules with plain arithmetic.
   function automatic exp_t model(input int unsigned d, input bit hex, input bit blank, input int t0);
      exp_t        e;
      int unsigned v;
      int          lat;
      e.dig   = '0;
      e.ovf   = 1'b0;
      e.value = d;
      if (hex) begin
         e.dig = (4*DIGITS)'(d);
         lat   = 1;
      end else if (d > 999999) begin
         e.dig = 24'h999999;
         e.ovf = 1'b1;
         lat   = 1;
      end else begin
         v = d;
         for (int i = 0; i < DIGITS; i++) begin
            e.dig[4*i +: 4] = 4'(v % 10);
            v = v / 10;
         end
         lat = WIDTH + 1;
      end
      if (!blank || e.ovf) begin
         e.en = '1;
      end else begin
         for (int i = 0; i < DIGITS; i++) e.en[i] = ((e.dig >> (4*i)) != 0);
         e.en[0] = 1'b1;
      end
      e.t_done = t0 + lat;
      return e;
   endfunction

   // Offer one value and wait for its transfer edge (bounded).
   task automatic send(input int unsigned d, input bit hex, input bit blank);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = WIDTH'(d);
      in_hex   = hex;
      in_blank = blank;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("accept_timeout", 32'(in_ready), 32'd1);
         in_valid = 1'b0;
         return;
      end
      // Transfer happens at the next rising edge; that edge is edge 0.
      exp_q.push_back(model(d, hex, blank, cyc + 1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Monitor: in_ready rising marks a completed update.
   logic                prev_ready = 1'b1;
   logic [4*DIGITS-1:0] shown = '0;

   always @(negedge clk) begin
      if (!reset_n) begin
         prev_ready = 1'b1;
         shown      = '0;
      end else begin
         if (!in_ready) check("digits_hold", 32'(digits), 32'(shown));
         if (in_ready && !prev_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_update", 32'(exp_q.size()), 32'd1);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check($sformatf("digits[%0d]", e.value), 32'(digits), 32'(e.dig));
               check($sformatf("digit_en[%0d]", e.value), 32'(digit_en), 32'(e.en));
               check($sformatf("overflow[%0d]", e.value), 32'(overflow), 32'(e.ovf));
               check($sformatf("latency[%0d]", e.value), 32'(cyc), 32'(e.t_done));
            end
            shown = digits;
         end
         prev_ready = in_ready;
      end
   end

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_digits"},   32'(digits),   32'd0);
      check({tag, "_digit_en"}, 32'(digit_en), 32'h3f);
      check({tag, "_overflow"}, 32'(overflow), 32'd0);
      check({tag, "_busy"},     32'(busy),     32'd0);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int unsigned d;
      int          sel;

      repeat (3) @(negedge clk);
      check_reset_vals("rst_hold");
      reset_n = 1'b1;
      @(negedge clk);
      check_reset_vals("rst_rel");

      // Directed cases.
      send(24'h00ABCD, 1'b1, 1'b1);
      send(123456, 1'b0, 1'b0);
      send(1000000, 1'b0, 1'b1);
      send(7, 1'b0, 1'b1);
      send(0, 1'b0, 1'b1);
      send(999999, 1'b0, 1'b1);
      send(24'hFFFFFF, 1'b0, 1'b1);
      send(24'h000000, 1'b1, 1'b1);
      send(24'h100000, 1'b1, 1'b1);
      // Backpressure: 42 is held valid throughout the conversion of 500.
      send(500, 1'b0, 1'b1);
      send(42, 1'b0, 1'b1);
      drain();

      // Reset at edge 10 of a conversion.
      send(654321, 1'b0, 1'b0);
      repeat (10) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_vals("rst_async");
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      send(31, 1'b0, 1'b0);
      drain();

      // Randomised traffic.
      for (int k = 0; k < 40; k++) begin
         sel = int'($urandom_range(0, 4));
         case (sel)
            0: d = $urandom_range(0, 999);
            1: d = $urandom_range(999990, 1000010);
            2: d = $urandom_range(0, 9) * 100000;
            default: d = $urandom() & 32'hFFFFFF;
         endcase
         send(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

endmodule
